adc_sample_fifo: RTL and testbench
==================================

Name: adc_sample_fifo

Overview:
- Consumes the per-channel deserialized ADC word and its one-cycle completion pulse, both already in the system clock domain.
- Applies programmable decimation and buffers kept samples in a first-word-fall-through (FWFT) FIFO.
- Presents samples on a valid/ready stream to the downstream packer/DMA.
- Tracks dropped samples for the control registers.

Parameters:
- DATA_WIDTH, 12, sample width; matches deserializer output.
- DEPTH, 16, FIFO entries; power of 2, minimum 4.
- DECIM_WIDTH, 8, width of decimation control.
- OVF_WIDTH, 16, width of overflow counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable (level).
- decim  in  DECIM_WIDTH  keep 1 of every decim+1 samples; 0 = keep all.
- sample_in  in  DATA_WIDTH  deserialized word; valid only in the sample_valid cycle.
- sample_valid  in  1  single-cycle read-complete pulse.
- clear_ovf  in  1  pulse; clears overflow_count and overflow_sticky.
- m_data  out  DATA_WIDTH  head-of-FIFO sample.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accept.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow_count  out  OVF_WIDTH  dropped kept-samples, saturating.
- overflow_sticky  out  1  set on any drop.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, pointers/level/decimation counter 0, FIFO contents don't-care.
- State machine:
  - IDLE: enable=1 -> ARM.
  - ARM: waits for the first sample_valid. That sample is kept (decimation phase aligned to it) -> RUN. enable=0 -> IDLE.
  - RUN: enable=0 -> DRAIN.
  - DRAIN: no writes; FIFO continues to pop. level==0 -> IDLE. enable=1 while in DRAIN is ignored until IDLE is reached.
- Decimation:
  - dcnt loads decim on every kept sample and decrements on each sample_valid in RUN.
  - A sample is kept when dcnt==0.
  - A new decim value takes effect at the next reload only.
  - decim=0 keeps every pulse.
- Write: a kept sample with FIFO not full writes sample_in at wr_ptr. Pointers wrap modulo DEPTH; an extra wrap bit distinguishes full from empty.
- Read: pop when m_valid && m_ready. m_data is the head entry; m_data and m_valid stay stable while m_valid && !m_ready.
- Latency: sample_valid in cycle N -> m_valid=1 and m_data=sample in cycle N+1 (empty FIFO).
- Simultaneous push and pop:
  - level unchanged.
  - At full, a pop in the same cycle frees the slot, so the write is accepted (no drop).
  - At empty, the push is not poppable until the next cycle.
- Overflow:
  - A kept sample arriving while full with no pop is dropped.
  - overflow_count +1, saturating at all-ones; overflow_sticky=1.
  - Decimated-away samples never count.
- clear_ovf with a simultaneous drop: count=1, sticky=1.
- sample_valid in IDLE or DRAIN is ignored: no write, no count.
- Reset mid-operation: immediate return to reset values; FIFO is emptied.

Test Plan:
- enable=1, decim=0, 5 pulses 0x001..0x005 spaced 6 clk, m_ready=1 -> m_data 0x001..0x005 in order, each 1 cycle after its pulse; level peaks at 1.
- decim=2, 9 pulses 0x010..0x018 -> output 0x010, 0x013, 0x016 only; overflow_count=0.
- m_ready=0, DEPTH+3 kept pulses -> level=16, overflow_count=3, sticky=1; then m_ready=1 -> first 16 values out, in order. Then clear_ovf -> count=0, sticky=0.
- FIFO full, m_ready=1 held, pulse coincident with a pop -> level stays 16, no overflow, new value appears last.
- enable dropped with level=4 -> busy stays 1 until 4 pops, then IDLE; pulses during DRAIN are not stored.
- rst asserted with level=7 mid-stream -> m_valid=0, level=0, busy=0 asynchronously; after release, enable -> first pulse stored cleanly.

Source files
------------

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: decimating first-word-fall-through sample buffer.
// Kept ADC samples are written into a DEPTH-entry FIFO and presented on a
// valid/ready stream; samples that arrive while the FIFO is full are dropped
// and counted.
// Ports:
//   clk, rst                 system clock, async active-high reset
//   enable                   capture enable (level)
//   decim                    keep 1 of every decim+1 samples
//   sample_in, sample_valid  deserialized word and its completion pulse
//   clear_ovf                clears overflow_count / overflow_sticky
//   m_data, m_valid, m_ready output stream (head of FIFO)
//   level                    FIFO occupancy 0..DEPTH
//   overflow_count           saturating count of dropped kept samples
//   overflow_sticky          set on any drop
//   busy                     capture state machine not idle
module adc_sample_fifo #(
   parameter int unsigned DATA_WIDTH  = 12,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned DECIM_WIDTH = 8,
   parameter int unsigned OVF_WIDTH   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [DECIM_WIDTH-1:0]   decim,
   input  logic [DATA_WIDTH-1:0]    sample_in,
   input  logic                     sample_valid,
   input  logic                     clear_ovf,
   output logic [DATA_WIDTH-1:0]    m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic [OVF_WIDTH-1:0]     overflow_count,
   output logic                     overflow_sticky,
   output logic                     busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

   state_t                 state, state_nxt;
   logic [DATA_WIDTH-1:0]  mem [DEPTH];
   logic [LW-1:0]          wr_ptr, rd_ptr, rd_nxt;
   logic [LW-1:0]          level_nxt;
   logic [DECIM_WIDTH-1:0] dcnt, dcnt_nxt;
   logic [DATA_WIDTH-1:0]  m_data_nxt;
   logic                   full, pop, keep, push, drop;

   // Wrap bits differ with equal indices only when full.
   assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop  = m_valid && m_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state, decimation and FIFO write/drop decisions.
   always_comb begin
      state_nxt = state;
      dcnt_nxt  = dcnt;
      keep      = 1'b0;
      case (state)
         IDLE: if (enable) state_nxt = ARM;
         ARM: begin
            if (!enable) state_nxt = IDLE;
            else if (sample_valid) begin
               // First sample aligns the decimation phase.
               keep      = 1'b1;
               dcnt_nxt  = decim;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (!enable) state_nxt = DRAIN;
            else if (sample_valid) begin
               if (dcnt == '0) begin
                  keep     = 1'b1;
                  dcnt_nxt = decim;
               end else begin
                  dcnt_nxt = dcnt - DECIM_WIDTH'(1);
               end
            end
         end
         DRAIN: if (level == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // A pop in the same cycle frees the slot of a full FIFO.
      push      = keep && (!full || pop);
      drop      = keep && full && !pop;
      level_nxt = level + LW'(push) - LW'(pop);
      rd_nxt    = rd_ptr + LW'(pop);
      // Head after this edge: bypass the incoming word when it lands at the head.
      if (level_nxt == '0)
         m_data_nxt = '0;
      else if (push && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0]))
         m_data_nxt = sample_in;
      else
         m_data_nxt = mem[rd_nxt[AW-1:0]];
   end

   // Pointers, registered stream outputs and status.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         level           <= '0;
         dcnt            <= '0;
         m_valid         <= 1'b0;
         m_data          <= '0;
         busy            <= 1'b0;
         overflow_count  <= '0;
         overflow_sticky <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + LW'(1);
         rd_ptr  <= rd_nxt;
         level   <= level_nxt;
         dcnt    <= dcnt_nxt;
         m_valid <= (level_nxt != '0);
         m_data  <= m_data_nxt;
         busy    <= (state_nxt != IDLE);
         // A drop coinciding with a clear leaves exactly that drop recorded.
         if (drop && clear_ovf) begin
            overflow_count  <= OVF_WIDTH'(1);
            overflow_sticky <= 1'b1;
         end else if (clear_ovf) begin
            overflow_count  <= '0;
            overflow_sticky <= 1'b0;
         end else if (drop) begin
            if (overflow_count != '1) overflow_count <= overflow_count + OVF_WIDTH'(1);
            overflow_sticky <= 1'b1;
         end
      end
   end

   // Sample storage; contents need no reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= sample_in;
   end

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Testbench for adc_sample_fifo: directed phases plus a randomized phase,
// all checked cycle by cycle against a queue-based reference model.
module tb_adc_sample_fifo;

   localparam int unsigned DW    = 12;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned DCW   = 8;
   localparam int unsigned OW    = 16;
   localparam int unsigned LW    = 5;

   localparam int M_IDLE  = 0;
   localparam int M_ARM   = 1;
   localparam int M_RUN   = 2;
   localparam int M_DRAIN = 3;

   logic           clk;
   logic           rst;
   logic           enable;
   logic [DCW-1:0] decim;
   logic [DW-1:0]  sample_in;
   logic           sample_valid;
   logic           clear_ovf;
   logic [DW-1:0]  m_data;
   logic           m_valid;
   logic           m_ready;
   logic [LW-1:0]  level;
   logic [OW-1:0]  overflow_count;
   logic           overflow_sticky;
   logic           busy;

   adc_sample_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DECIM_WIDTH(DCW), .OVF_WIDTH(OW)) dut (
      .clk(clk), .rst(rst), .enable(enable), .decim(decim),
      .sample_in(sample_in), .sample_valid(sample_valid), .clear_ovf(clear_ovf),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
      .overflow_count(overflow_count), .overflow_sticky(overflow_sticky), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int peak;

   // Reference model state.
   logic [DW-1:0] mq[$];
   int            mode;
   int            skip;
   int            ocnt;
   bit            osticky;

   logic [DW-1:0] out_q[$];
   logic [DW-1:0] sent[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mode    = M_IDLE;
      skip    = 0;
      ocnt    = 0;
      osticky = 1'b0;
   endtask

   // One clock edge of the behavioural model, using the inputs set for it.
   task automatic model_step(input bit sv, input logic [DW-1:0] d);
      bit popm, kept, dropm;
      int pre_size;
      pre_size = mq.size();
      popm     = (pre_size > 0) && m_ready;
      kept     = 1'b0;
      if (mode == M_IDLE) begin
         if (enable) mode = M_ARM;
      end else if (mode == M_ARM) begin
         if (!enable) mode = M_IDLE;
         else if (sv) begin kept = 1'b1; skip = int'(decim); mode = M_RUN; end
      end else if (mode == M_RUN) begin
         if (!enable) mode = M_DRAIN;
         else if (sv) begin
            if (skip == 0) begin kept = 1'b1; skip = int'(decim); end
            else skip = skip - 1;
         end
      end else begin
         if (pre_size == 0) mode = M_IDLE;
      end
      if (popm) void'(mq.pop_front());
      dropm = kept && (pre_size == DEPTH) && !popm;
      if (kept && !dropm) mq.push_back(d);
      if (dropm && clear_ovf) begin ocnt = 1; osticky = 1'b1; end
      else if (clear_ovf) begin ocnt = 0; osticky = 1'b0; end
      else if (dropm) begin
         if (ocnt < 65535) ocnt = ocnt + 1;
         osticky = 1'b1;
      end
   endtask

   task automatic compare_all(input string ph);
      chk({ph, "_m_valid"}, 32'(m_valid), 32'(mq.size() > 0));
      chk({ph, "_m_data"}, 32'(m_data), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
      chk({ph, "_level"}, 32'(level), 32'(mq.size()));
      chk({ph, "_ovf_count"}, 32'(overflow_count), 32'(ocnt));
      chk({ph, "_ovf_sticky"}, 32'(overflow_sticky), 32'(osticky));
      chk({ph, "_busy"}, 32'(busy), 32'(mode != M_IDLE));
   endtask

   // Drive one clock cycle, step the model, compare after the edge.
   task automatic cycle(input string ph, input bit sv, input logic [DW-1:0] d);
      @(negedge clk);
      sample_valid = sv;
      sample_in    = sv ? d : DW'($urandom);
      if (m_valid && m_ready) out_q.push_back(m_data);
      if (rst) model_reset();
      else     model_step(sv, d);
      @(posedge clk);
      #1;
      if (int'(level) > peak) peak = int'(level);
      compare_all(ph);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] v;
      int            n;
      bit            done;

      rst = 1'b1; enable = 1'b0; decim = '0; sample_in = '0;
      sample_valid = 1'b0; clear_ovf = 1'b0; m_ready = 1'b0;
      model_reset();
      peak = 0;
      repeat (2) cycle("reset", 1'b0, '0);
      chk("reset_m_data_zero", 32'(m_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Keep-all decimation, samples pass through one cycle after the pulse.
      enable = 1'b1; decim = 8'd0; m_ready = 1'b1;
      repeat (2) cycle("t1", 1'b0, '0);
      for (int i = 1; i <= 5; i++) begin
         v = DW'(i);
         cycle("t1", 1'b1, v);
         chk("t1_latency_valid", 32'(m_valid), 32'd1);
         chk("t1_latency_data", 32'(m_data), 32'(i));
         repeat (5) cycle("t1", 1'b0, '0);
      end
      chk("t1_peak_level", 32'(peak), 32'd1);

      // Decimate by 3.
      decim = 8'd2;
      out_q.delete();
      for (int i = 0; i < 9; i++) begin
         cycle("t2", 1'b1, DW'(12'h010 + i));
         cycle("t2", 1'b0, '0);
      end
      repeat (3) cycle("t2", 1'b0, '0);
      chk("t2_out_count", 32'(out_q.size()), 32'd3);
      if (out_q.size() == 3) begin
         chk("t2_out0", 32'(out_q[0]), 32'h010);
         chk("t2_out1", 32'(out_q[1]), 32'h013);
         chk("t2_out2", 32'(out_q[2]), 32'h016);
      end
      chk("t2_no_overflow", 32'(overflow_count), 32'd0);

      // Overflow with a stalled consumer.
      decim = 8'd0; m_ready = 1'b0;
      sent.delete();
      for (int i = 0; i < DEPTH + 3; i++) begin
         v = DW'($urandom);
         sent.push_back(v);
         cycle("t3", 1'b1, v);
      end
      chk("t3_level_full", 32'(level), 32'd16);
      chk("t3_ovf_count", 32'(overflow_count), 32'd3);
      chk("t3_ovf_sticky", 32'(overflow_sticky), 32'd1);
      m_ready = 1'b1;
      out_q.delete();
      repeat (DEPTH + 2) cycle("t3", 1'b0, '0);
      chk("t3_drain_count", 32'(out_q.size()), 32'(DEPTH));
      for (int i = 0; i < out_q.size() && i < DEPTH; i++)
         chk("t3_drain_order", 32'(out_q[i]), 32'(sent[i]));
      clear_ovf = 1'b1;
      cycle("t3", 1'b0, '0);
      clear_ovf = 1'b0;
      chk("t3_clear_count", 32'(overflow_count), 32'd0);
      chk("t3_clear_sticky", 32'(overflow_sticky), 32'd0);

      // Push into a full FIFO coincident with a pop.
      m_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) cycle("t4", 1'b1, DW'(12'h100 + i));
      chk("t4_level_full", 32'(level), 32'd16);
      m_ready = 1'b1;
      out_q.delete();
      cycle("t4", 1'b1, 12'h5A5);
      chk("t4_level_held", 32'(level), 32'd16);
      chk("t4_no_overflow", 32'(overflow_count), 32'd0);
      repeat (DEPTH + 1) cycle("t4", 1'b0, '0);
      chk("t4_out_count", 32'(out_q.size()), 32'd17);
      if (out_q.size() > 0) chk("t4_new_last", 32'(out_q[out_q.size()-1]), 32'h5A5);

      // Drain after disable; pulses during drain are not stored.
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) cycle("t5", 1'b1, DW'(12'h200 + i));
      chk("t5_level4", 32'(level), 32'd4);
      enable = 1'b0;
      repeat (3) cycle("t5", 1'b1, 12'h7FF);
      chk("t5_busy_drain", 32'(busy), 32'd1);
      chk("t5_level_held", 32'(level), 32'd4);
      m_ready = 1'b1;
      out_q.delete();
      done = 1'b0;
      n = 0;
      while (!done && n < 30) begin
         cycle("t5", n[0], 12'h6EE);
         n++;
         if (!busy) done = 1'b1;
      end
      chk("t5_reached_idle", 32'(done), 32'd1);
      chk("t5_pops", 32'(out_q.size()), 32'd4);
      chk("t5_level_empty", 32'(level), 32'd0);

      // Asynchronous reset mid-stream.
      enable = 1'b1; decim = 8'd0; m_ready = 1'b0;
      cycle("t6", 1'b0, '0);
      for (int i = 0; i < 7; i++) cycle("t6", 1'b1, DW'(12'h300 + i));
      chk("t6_level7", 32'(level), 32'd7);
      #2 rst = 1'b1;
      #1;
      chk("t6_async_m_valid", 32'(m_valid), 32'd0);
      chk("t6_async_level", 32'(level), 32'd0);
      chk("t6_async_busy", 32'(busy), 32'd0);
      model_reset();
      repeat (2) cycle("t6", 1'b0, '0);
      rst = 1'b0;
      m_ready = 1'b1;
      cycle("t6", 1'b0, '0);
      cycle("t6", 1'b1, 12'hABC);
      chk("t6_first_valid", 32'(m_valid), 32'd1);
      chk("t6_first_data", 32'(m_data), 32'hABC);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         enable    = ($urandom_range(0, 29) != 0);
         m_ready   = ($urandom_range(0, 9) < 6);
         clear_ovf = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 49) == 0) decim = DCW'($urandom_range(0, 3));
         cycle("rand", $urandom_range(0, 1) == 1, DW'($urandom));
      end
      clear_ovf = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
